universal_shift_reg_n: RTL and testbench
========================================

# universal_shift_reg_n

Parametrised universal shift register, successor to the fixed 4-bit universal shift register. Supports hold, bidirectional logical shift, parallel load, arithmetic right shift and optional rotate on a WIDTH-bit register. Adds a clock-enable and a counted burst-shift engine with busy/done handshake. Sits in the day-13 datapath library as the general-purpose serialiser/deserialiser and barrel-shift substitute.

## Interface
- WIDTH, 8, register width; legal range WIDTH ≥ 2
- CNT_W, 4, width of the burst count; legal range CNT_W ≥ 1
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  single-step enable; sampled only when idle
- mode  input  3  operation select (see Operation)
- serial_in  input  1  serial data shifted into the vacated end
- parallel_in  input  WIDTH  load data for mode 011
- start  input  1  burst request; sampled only when idle
- count  input  CNT_W  number of shift steps in a burst
- parallel_out  output  WIDTH  register contents q
- serial_out  output  1  q[0] if last direction was right, q[WIDTH-1] if left
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- Modes:
  - 000 hold
  - 001 shift right: q ← {serial_in, q[WIDTH-1:1]}
  - 010 shift left: q ← {q[WIDTH-2:0], serial_in}
  - 011 parallel load: q ← parallel_in
  - 100 rotate right
  - 101 rotate left
  - 110 arithmetic right: q ← {q[WIDTH-1], q[WIDTH-1:1]}
  - 111 reserved, behaves as hold
- Direction flag dir, internal state, reset value 0 (right).
  - Set to 1 by any executed 010/101 step.
  - Cleared to 0 by any executed 001/100/110 step.
  - Unchanged by load and hold.
- serial_out is derived from q and dir only; there is no combinational path from mode.
- States:
  - IDLE: busy = 0.
  - BURST: busy = 1; holds latched bmode and the remaining-step counter rem.
- IDLE, start = 1, count ≠ 0, mode ∈ {001, 010, 100, 101, 110}: latch bmode ← mode and rem ← count, then go to BURST. No shift on this edge. start takes priority over en.
- IDLE, start = 1 with count = 0 or a non-shift mode: no shift; done pulses on the next edge. busy stays 0.
- IDLE, start = 0, en = 1: execute mode once.
- IDLE, start = 0, en = 0: hold.
- BURST: each edge executes one bmode step and decrements rem.
  - serial_in is sampled live on each step.
  - en, mode, start, count and parallel_in are ignored.
  - On the step where rem reaches 0: go to IDLE and assert done for exactly one cycle.
- Reset at any time:
  - q = 0, dir = 0, rem = 0, busy = 0, done = 0, state = IDLE.
  - A burst in progress is aborted and done is not asserted.

## Timing
- Single step: q updates on the same edge that samples en = 1.
- Burst of N steps, start sampled at edge E0:
  - busy rises after E0.
  - Steps execute at edges E1..EN.
  - busy falls and done rises after EN.
  - done falls after EN+1.
  - busy is high for exactly N cycles. Start-to-done latency is N+1 edges.
- start re-asserted in the cycle after done (IDLE) is accepted. start during busy is dropped and not queued.
- Outputs are registered or derived from registers only; no input-to-output combinational path.

## Configuration
- USR_ROTATE_EN defined:
  - Modes 100/101 rotate as specified.
  - Both are valid burst modes.
- USR_ROTATE_EN undefined:
  - Modes 100/101 behave as hold and leave dir unchanged.
  - A start with mode 100/101 is treated as a non-shift burst: done pulses next edge, busy stays 0.

## Test plan
- Reset asserted mid-simulation → parallel_out = 0, serial_out = 0, busy = 0, done = 0 immediately, without waiting for a clk edge.
- WIDTH = 8: load 8'hA5 (en = 1, mode = 011), then mode = 001 with serial_in = 1 → parallel_out = 8'hD2, serial_out = 0.
- USR_ROTATE_EN defined: load 8'h81, then mode = 101 one step → parallel_out = 8'h03, serial_out = 0 (dir = left).
- Load 8'h80, then start = 1, mode = 110, count = 3:
  - busy is high for 3 cycles.
  - parallel_out = 8'hF0 at the 3rd step.
  - done is high for exactly 1 cycle.
  - en and mode toggling during the burst has no effect.
- Start a burst with count = 10, assert reset after the 4th step → parallel_out = 0, busy = 0, done is never asserted. A new start is accepted afterwards.
- USR_ROTATE_EN undefined: load 8'h81, then mode = 100, en = 1 → parallel_out stays 8'h81. start with mode = 100, count = 5 → busy stays 0 and done pulses on the next edge.

Source files
------------

// File: rtl/universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// universal_shift_reg_n
//
// Parametrised universal shift register with a single-step path and a counted
// burst-shift engine. Operations: hold, logical shift right/left, parallel
// load, arithmetic shift right and (optionally) rotate right/left.
//
// Optional feature macro: USR_ROTATE_EN
//   defined   : modes 100/101 rotate and are legal burst modes.
//   undefined : modes 100/101 act as hold (dir untouched) and a burst start
//               with them completes immediately like any non-shift start.
//
// Parameters
//   WIDTH        register width (>= 2)
//   CNT_W        width of the burst step count (>= 1)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state
//   en           single-step enable (sampled only when idle)
//   mode[2:0]    operation select
//   serial_in    bit shifted into the vacated end (sampled live every step)
//   parallel_in  load data for mode 011
//   start        burst request (sampled only when idle, wins over en)
//   count        number of steps in a burst
//   parallel_out register contents
//   serial_out   q[0] after a rightward step, q[WIDTH-1] after a leftward one
//   busy         high while a burst is running
//   done         one-cycle pulse when a burst (or a degenerate start) ends
// -----------------------------------------------------------------------------
module universal_shift_reg_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  // Controller states
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  // Operation codes (000 hold and 111 reserved fall through to hold)
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
`ifdef USR_ROTATE_EN
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
`endif
  localparam logic [2:0] MODE_SAR  = 3'b110;

  // Architectural state
  logic [WIDTH-1:0] q_reg,     q_next;
  logic             dir_reg,   dir_next;   // 0 = last step went right, 1 = left
  logic [0:0]       state_reg, state_next;
  logic [2:0]       bmode_reg, bmode_next;
  logic [CNT_W-1:0] rem_reg,   rem_next;
  logic             done_reg,  done_next;

  // Candidate results for each shifting operation
  logic [WIDTH-1:0] shr_q;
  logic [WIDTH-1:0] shl_q;
  logic [WIDTH-1:0] sar_q;
`ifdef USR_ROTATE_EN
  logic [WIDTH-1:0] ror_q;
  logic [WIDTH-1:0] rol_q;
`endif

  // Operation actually executed this edge and its outcome
  logic [2:0]       op_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_dir;

  // Modes that are allowed to run as a counted burst.
  function automatic logic is_burst_mode(input logic [2:0] m);
    case (m)
      MODE_SHR, MODE_SHL, MODE_SAR: return 1'b1;
`ifdef USR_ROTATE_EN
      MODE_ROR, MODE_ROL:           return 1'b1;
`endif
      default:                      return 1'b0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Bit-level shift networks
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign shr_q[gi]     = q_reg[gi+1];
      assign shl_q[gi+1]   = q_reg[gi];
      assign sar_q[gi]     = q_reg[gi+1];
`ifdef USR_ROTATE_EN
      assign ror_q[gi]     = q_reg[gi+1];
      assign rol_q[gi+1]   = q_reg[gi];
`endif
    end
  endgenerate

  // End bits: serial_in fills the vacated end for logical shifts, the sign
  // bit is replicated for arithmetic shifts, rotates wrap around.
  assign shr_q[WIDTH-1] = serial_in;
  assign shl_q[0]       = serial_in;
  assign sar_q[WIDTH-1] = q_reg[WIDTH-1];
`ifdef USR_ROTATE_EN
  assign ror_q[WIDTH-1] = q_reg[0];
  assign rol_q[0]       = q_reg[WIDTH-1];
`endif

  // ---------------------------------------------------------------------------
  // Step datapath: while bursting the latched mode is used, otherwise the
  // live mode input. Load can never reach here from a burst because it is
  // not a legal burst mode.
  // ---------------------------------------------------------------------------
  assign op_mode = (state_reg == ST_BURST) ? bmode_reg : mode;

  always_comb begin
    step_q   = q_reg;
    step_dir = dir_reg;
    case (op_mode)
      MODE_SHR: begin
        step_q   = shr_q;
        step_dir = 1'b0;
      end
      MODE_SHL: begin
        step_q   = shl_q;
        step_dir = 1'b1;
      end
      MODE_LOAD: begin
        step_q   = parallel_in;
      end
`ifdef USR_ROTATE_EN
      MODE_ROR: begin
        step_q   = ror_q;
        step_dir = 1'b0;
      end
      MODE_ROL: begin
        step_q   = rol_q;
        step_dir = 1'b1;
      end
`endif
      MODE_SAR: begin
        step_q   = sar_q;
        step_dir = 1'b0;
      end
      default: begin
        // hold / reserved / rotate when rotation is compiled out
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------------
  always_comb begin
    q_next     = q_reg;
    dir_next   = dir_reg;
    state_next = state_reg;
    bmode_next = bmode_reg;
    rem_next   = rem_reg;
    done_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          // start has priority over en; no data movement on this edge.
          if ((count != '0) && is_burst_mode(mode)) begin
            bmode_next = mode;
            rem_next   = count;
            state_next = ST_BURST;
          end else begin
            // Degenerate request: complete immediately without going busy.
            done_next  = 1'b1;
          end
        end else if (en) begin
          q_next   = step_q;
          dir_next = step_dir;
        end
      end

      ST_BURST: begin
        q_next   = step_q;
        dir_next = step_dir;
        rem_next = rem_reg - CNT_W'(1);
        // rem_reg == 1 means this edge executes the final step.
        if (rem_reg == CNT_W'(1)) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_reg     <= '0;
      dir_reg   <= 1'b0;
      state_reg <= ST_IDLE;
      bmode_reg <= '0;
      rem_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      q_reg     <= q_next;
      dir_reg   <= dir_next;
      state_reg <= state_next;
      bmode_reg <= bmode_next;
      rem_reg   <= rem_next;
      done_reg  <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all taken from registers, never from inputs.
  // ---------------------------------------------------------------------------
  assign parallel_out = q_reg;
  assign serial_out   = dir_reg ? q_reg[WIDTH-1] : q_reg[0];
  assign busy         = (state_reg == ST_BURST);
  assign done         = done_reg;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// -----------------------------------------------------------------------------
// Testbench for universal_shift_reg_n (WIDTH = 8, CNT_W = 4).
// Works with and without USR_ROTATE_EN defined.
// -----------------------------------------------------------------------------
module tb_universal_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] parallel_out;
  logic             serial_out;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;

  // Reference state: register value and last shift direction (1 = left)
  logic [7:0] m_q;
  logic       m_dir;

  universal_shift_reg_n #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .mode         (mode),
    .serial_in    (serial_in),
    .parallel_in  (parallel_in),
    .start        (start),
    .count        (count),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference operation written as plain arithmetic on the register value.
  // Returns {dir, q}.
  function automatic logic [8:0] ref_step(input logic [7:0] q, input logic d,
                                          input logic [2:0] m, input logic sin,
                                          input logic [7:0] pin);
    int v;
    int nd;
    v  = int'(q);
    nd = int'(d);
    case (m)
      3'd1: begin v = v / 2 + int'(sin) * 128;           nd = 0; end
      3'd2: begin v = (v * 2 + int'(sin)) % 256;         nd = 1; end
      3'd3: begin v = int'(pin);                                 end
`ifdef USR_ROTATE_EN
      3'd4: begin v = v / 2 + (v % 2) * 128;             nd = 0; end
      3'd5: begin v = (v * 2) % 256 + v / 128;           nd = 1; end
`endif
      3'd6: begin v = v / 2 + ((v >= 128) ? 128 : 0);    nd = 0; end
      default: ;
    endcase
    return {nd[0], v[7:0]};
  endfunction

  function automatic logic ref_so(input logic [7:0] q, input logic d);
    return d ? q[7] : q[0];
  endfunction

  function automatic bit ref_burstable(input logic [2:0] m);
`ifdef USR_ROTATE_EN
    return m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
`else
    return m inside {3'd1, 3'd2, 3'd6};
`endif
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 3'd0; serial_in = 1'b0;
    parallel_in = '0; start = 1'b0; count = '0;
    tick(); tick();
    checks++;
    if ({parallel_out, serial_out, busy, done} !== 11'h0) begin
      errors++;
      $display("FAIL reset_init: got q=%h so=%b busy=%b done=%b, want all 0",
               parallel_out, serial_out, busy, done);
    end
    reset = 1'b0;
    m_q = 8'h00; m_dir = 1'b0;

    // Fill with ones and shift left so serial_out would read 1.
    en = 1'b1; mode = 3'd3; parallel_in = 8'hFF; tick();
    mode = 3'd2; serial_in = 1'b1; tick();
    en = 1'b0;
    checks++;
    if ({parallel_out, serial_out} !== {8'hFF, 1'b1}) begin
      errors++;
      $display("FAIL reset_pre: got q=%h so=%b, want q=ff so=1",
               parallel_out, serial_out);
    end
    // Assert reset between edges and look before the next edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({parallel_out, serial_out, busy, done} !== 11'h0) begin
      errors++;
      $display("FAIL reset_async: got q=%h so=%b busy=%b done=%b, want all 0",
               parallel_out, serial_out, busy, done);
    end
    tick();
    reset = 1'b0;
    m_q = 8'h00; m_dir = 1'b0;
    $display("txn reset: q=%h so=%b", parallel_out, serial_out);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_load_shift();
    en = 1'b1; mode = 3'd3; parallel_in = 8'hA5; tick();
    checks++;
    if (parallel_out !== 8'hA5) begin
      errors++;
      $display("FAIL load: got q=%h want a5", parallel_out);
    end
    mode = 3'd1; serial_in = 1'b1; tick();
    en = 1'b0;
    checks++;
    if ({parallel_out, serial_out, busy, done} !== {8'hD2, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL shr: got q=%h so=%b busy=%b done=%b, want q=d2 so=0 busy=0 done=0",
               parallel_out, serial_out, busy, done);
    end
    m_q = 8'hD2; m_dir = 1'b0;
    $display("txn load a5 + shr: q=%h so=%b", parallel_out, serial_out);
  endtask

  // ---------------------------------------------------------------------------
`ifdef USR_ROTATE_EN
  task automatic test_rotate();
    en = 1'b1; mode = 3'd3; parallel_in = 8'h81; tick();
    mode = 3'd5; tick();
    en = 1'b0;
    checks++;
    if ({parallel_out, serial_out} !== {8'h03, 1'b0}) begin
      errors++;
      $display("FAIL rol: got q=%h so=%b, want q=03 so=0", parallel_out, serial_out);
    end
    en = 1'b1; mode = 3'd4; tick();
    en = 1'b0;
    checks++;
    if ({parallel_out, serial_out} !== {8'h81, 1'b1}) begin
      errors++;
      $display("FAIL ror: got q=%h so=%b, want q=81 so=1", parallel_out, serial_out);
    end
    m_q = 8'h81; m_dir = 1'b0;
    $display("txn rotate: q=%h so=%b", parallel_out, serial_out);
  endtask
`else
  task automatic test_rotate_disabled();
    logic exp_so;
    en = 1'b1; mode = 3'd3; parallel_in = 8'h81; tick();
    m_q = 8'h81;
    mode = 3'd4; tick();
    exp_so = ref_so(m_q, m_dir);
    checks++;
    if ({parallel_out, serial_out} !== {8'h81, exp_so}) begin
      errors++;
      $display("FAIL ror_off: got q=%h so=%b, want q=81 so=%b",
               parallel_out, serial_out, exp_so);
    end
    mode = 3'd5; tick();
    en = 1'b0;
    checks++;
    if ({parallel_out, serial_out} !== {8'h81, exp_so}) begin
      errors++;
      $display("FAIL rol_off: got q=%h so=%b, want q=81 so=%b",
               parallel_out, serial_out, exp_so);
    end
    start = 1'b1; mode = 3'd4; count = 4'd5; tick();
    start = 1'b0;
    checks++;
    if ({parallel_out, busy, done} !== {8'h81, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL ror_burst_off: got q=%h busy=%b done=%b, want q=81 busy=0 done=1",
               parallel_out, busy, done);
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL ror_burst_off_end: got busy=%b done=%b, want 0 0", busy, done);
    end
    $display("txn rotate disabled: q=%h", parallel_out);
  endtask
`endif

  // ---------------------------------------------------------------------------
  task automatic test_arith_burst();
    logic [7:0] exp_q [1:3];
    exp_q[1] = 8'hC0; exp_q[2] = 8'hE0; exp_q[3] = 8'hF0;
    en = 1'b1; mode = 3'd3; parallel_in = 8'h80; tick();
    en = 1'b0; start = 1'b1; mode = 3'd6; count = 4'd3; tick();
    checks++;
    if ({parallel_out, busy, done} !== {8'h80, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sar_accept: got q=%h busy=%b done=%b, want q=80 busy=1 done=0",
               parallel_out, busy, done);
    end
    start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      en = ~en; mode = (k % 2 == 1) ? 3'd3 : 3'd2;
      parallel_in = 8'h5A; serial_in = 1'b1;
      tick();
      checks++;
      if ({parallel_out, busy, done} !== {exp_q[k], (k < 3), (k == 3)}) begin
        errors++;
        $display("FAIL sar_step%0d: got q=%h busy=%b done=%b, want q=%h busy=%b done=%b",
                 k, parallel_out, busy, done, exp_q[k], (k < 3), (k == 3));
      end
    end
    en = 1'b0; mode = 3'd0;
    tick();
    checks++;
    if ({parallel_out, busy, done, serial_out} !== {8'hF0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sar_end: got q=%h busy=%b done=%b so=%b, want q=f0 busy=0 done=0 so=0",
               parallel_out, busy, done, serial_out);
    end
    m_q = 8'hF0; m_dir = 1'b0;
    $display("txn sar burst 3: q=%h", parallel_out);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_burst_abort();
    bit saw_done;
    start = 1'b1; mode = 3'd1; count = 4'd10; en = 1'b0; tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_accept: got busy=%b want 1", busy);
    end
    for (int k = 1; k <= 4; k++) begin
      serial_in = 1'($urandom_range(0, 1));
      tick();
    end
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++;
      $display("FAIL abort_mid: got busy=%b done=%b want 1 0", busy, done);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({parallel_out, serial_out, busy, done} !== 11'h0) begin
      errors++;
      $display("FAIL abort_reset: got q=%h so=%b busy=%b done=%b, want all 0",
               parallel_out, serial_out, busy, done);
    end
    tick();
    reset = 1'b0;
    m_q = 8'h00; m_dir = 1'b0;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet: got busy/done activity after abort, want none");
    end
    // Fresh burst accepted after the abort.
    start = 1'b1; mode = 3'd2; count = 4'd2; serial_in = 1'b1; tick();
    start = 1'b0;
    tick();
    checks++;
    if ({parallel_out, busy, done} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_restart1: got q=%h busy=%b done=%b, want q=01 busy=1 done=0",
               parallel_out, busy, done);
    end
    tick();
    checks++;
    if ({parallel_out, serial_out, busy, done} !== {8'h03, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL abort_restart2: got q=%h so=%b busy=%b done=%b, want q=03 so=0 busy=0 done=1",
               parallel_out, serial_out, busy, done);
    end
    tick();
    m_q = 8'h03; m_dir = 1'b1;
    $display("txn abort + restart: q=%h", parallel_out);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [8:0] r;
    start = 1'b1; mode = 3'd2; count = 4'd2; en = 1'b0; tick();
    for (int k = 1; k <= 2; k++) begin
      // A competing request during busy must be dropped.
      start = 1'b1; mode = 3'd1; count = 4'd5;
      serial_in = 1'($urandom_range(0, 1));
      tick();
      r = ref_step(m_q, m_dir, 3'd2, serial_in, 8'h00);
      m_q = r[7:0]; m_dir = r[8];
    end
    checks++;
    if ({parallel_out, busy, done} !== {m_q, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_first: got q=%h busy=%b done=%b, want q=%h busy=0 done=1",
               parallel_out, busy, done, m_q);
    end
    start = 1'b1; mode = 3'd6; count = 4'd1; tick();
    start = 1'b0;
    checks++;
    if ({parallel_out, busy, done} !== {m_q, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_accept: got q=%h busy=%b done=%b, want q=%h busy=1 done=0",
               parallel_out, busy, done, m_q);
    end
    tick();
    r = ref_step(m_q, m_dir, 3'd6, serial_in, 8'h00);
    m_q = r[7:0]; m_dir = r[8];
    checks++;
    if ({parallel_out, serial_out, busy, done} !== {m_q, ref_so(m_q, m_dir), 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL b2b_second: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=0 done=1",
               parallel_out, serial_out, busy, done, m_q, ref_so(m_q, m_dir));
    end
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: got busy=%b done=%b want 0 0", busy, done);
    end
    $display("txn back-to-back: q=%h", parallel_out);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random();
    logic [8:0] r;
    logic [2:0] bm;
    int         n;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        // Single step (or idle when en = 0)
        en = 1'($urandom_range(0, 1)); mode = 3'($urandom_range(0, 7));
        serial_in = 1'($urandom_range(0, 1)); parallel_in = 8'($urandom);
        start = 1'b0;
        tick();
        if (en) begin
          r = ref_step(m_q, m_dir, mode, serial_in, parallel_in);
          m_q = r[7:0]; m_dir = r[8];
        end
        checks++;
        if ({parallel_out, serial_out, busy, done} !== {m_q, ref_so(m_q, m_dir), 2'b00}) begin
          errors++;
          $display("FAIL rnd_step t=%0d: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=0 done=0",
                   t, parallel_out, serial_out, busy, done, m_q, ref_so(m_q, m_dir));
        end
        $display("txn %0d step en=%b mode=%0d q=%h", t, en, mode, parallel_out);
        en = 1'b0;
      end else begin
        // Burst request, possibly degenerate; en is random to exercise priority.
        bm = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 7))
                                         : ((($urandom_range(0, 2)) == 0) ? 3'd6 : 3'($urandom_range(1, 2)));
        n = int'($urandom_range(0, 6));
        mode = bm; count = 4'(n); start = 1'b1;
        en = 1'($urandom_range(0, 1)); parallel_in = 8'($urandom);
        tick();
        if (n != 0 && ref_burstable(bm)) begin
          checks++;
          if ({parallel_out, busy, done} !== {m_q, 2'b10}) begin
            errors++;
            $display("FAIL rnd_accept t=%0d: got q=%h busy=%b done=%b, want q=%h busy=1 done=0",
                     t, parallel_out, busy, done, m_q);
          end
          for (int k = 1; k <= n; k++) begin
            serial_in = 1'($urandom_range(0, 1));
            en = 1'($urandom_range(0, 1)); mode = 3'($urandom_range(0, 7));
            start = 1'($urandom_range(0, 1)); count = 4'($urandom);
            parallel_in = 8'($urandom);
            tick();
            r = ref_step(m_q, m_dir, bm, serial_in, 8'h00);
            m_q = r[7:0]; m_dir = r[8];
            checks++;
            if ({parallel_out, serial_out, busy, done} !==
                {m_q, ref_so(m_q, m_dir), (k < n), (k == n)}) begin
              errors++;
              $display("FAIL rnd_burst t=%0d k=%0d: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=%b done=%b",
                       t, k, parallel_out, serial_out, busy, done,
                       m_q, ref_so(m_q, m_dir), (k < n), (k == n));
            end
          end
        end else begin
          checks++;
          if ({parallel_out, busy, done} !== {m_q, 2'b01}) begin
            errors++;
            $display("FAIL rnd_degenerate t=%0d: got q=%h busy=%b done=%b, want q=%h busy=0 done=1",
                     t, parallel_out, busy, done, m_q);
          end
        end
        start = 1'b0; en = 1'b0;
        tick();
        checks++;
        if ({parallel_out, busy, done} !== {m_q, 2'b00}) begin
          errors++;
          $display("FAIL rnd_after t=%0d: got q=%h busy=%b done=%b, want q=%h busy=0 done=0",
                   t, parallel_out, busy, done, m_q);
        end
        $display("txn %0d burst mode=%0d count=%0d q=%h", t, bm, n, parallel_out);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_load_shift();
`ifdef USR_ROTATE_EN
    test_rotate();
`else
    test_rotate_disabled();
`endif
    test_arith_burst();
    test_burst_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
